// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state encoding and instruction field positions
// shared by the exec_ctrl sequencer and its decoder.
package exec_pkg;

  localparam logic [3:0] OP_SHL  = 4'h0;
  localparam logic [3:0] OP_SHR  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_IOR  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_ZTST = 4'h7;
  localparam logic [3:0] OP_PCZ  = 4'h8;
  localparam logic [3:0] OP_PCNZ = 4'h9;
  localparam logic [3:0] OP_NOP  = 4'hA;

  // Instruction word layout: [15:12] opcode, [11] dest, [10:0] data address
  localparam int unsigned IR_OP_HI = 15;
  localparam int unsigned IR_OP_LO = 12;
  localparam int unsigned IR_DEST  = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READ,
    ST_EXEC,
    ST_WB
  } state_t;

  // Opcodes 0..7 (SHL through ZTST) write their result back
  function automatic logic op_writes_back(input logic [3:0] op);
    return (op <= OP_ZTST);
  endfunction

endpackage

// File: rtl/exec_decode.sv
// exec_decode: combinational instruction-register decode.
module exec_decode
  import exec_pkg::*;
#(
  parameter int unsigned DA_W = 11
) (
  input  logic [15:0]     ir,
  output logic [3:0]      alu_op,
  output logic            writes_back,
  output logic            dest_mem,
  output logic [DA_W-1:0] daddr
);

  // Split the IR into its fields and classify the opcode
  always_comb begin
    alu_op      = ir[IR_OP_HI:IR_OP_LO];
    writes_back = op_writes_back(ir[IR_OP_HI:IR_OP_LO]);
    dest_mem    = ir[IR_DEST];
    daddr       = ir[DA_W-1:0];
  end

endmodule

// File: rtl/exec_ctrl.sv
// exec_ctrl: 4-cycle fetch/read/execute/write-back sequencer driving a
// 16-bit combinational ALU. Optional single-step input: EXEC_CTRL_STEP_EN.
module exec_ctrl
  import exec_pkg::*;
#(
  parameter int unsigned PC_W = 11,
  parameter int unsigned DA_W = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
`ifdef EXEC_CTRL_STEP_EN
  input  logic            step,
`endif
  output logic            halted,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [DA_W-1:0] dmem_addr,
  input  logic [15:0]     dmem_rdata,
  output logic [15:0]     dmem_wdata,
  output logic            dmem_we,
  output logic [3:0]      alu_op,
  output logic [15:0]     alu_mem,
  output logic [15:0]     alu_wreg,
  output logic            alu_carry_in,
  output logic            alu_zero_in,
  input  logic [15:0]     alu_result,
  input  logic            alu_carry_out,
  input  logic            alu_zero_out,
  input  logic            alu_pc_skip,
  output logic [15:0]     wreg
);

  state_t            state_q, state_d;
  logic [15:0]       ir_q;
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       w_q;
  logic              c_q, z_q;
  logic [15:0]       result_q;
  logic              skip_q;
  logic              start;
  logic              writes_back, dest_mem;
  logic [DA_W-1:0]   ir_daddr;

  exec_decode #(.DA_W(DA_W)) u_decode (
    .ir          (ir_q),
    .alu_op      (alu_op),
    .writes_back (writes_back),
    .dest_mem    (dest_mem),
    .daddr       (ir_daddr)
  );

`ifdef EXEC_CTRL_STEP_EN
  assign start = run | step;
`else
  assign start = run;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded outputs.
  // The instruction RAM returns the word during READ, one cycle before IR
  // holds it, so the data address is taken straight from imem_data in READ.
  always_comb begin
    state_d   = state_q;
    halted    = 1'b0;
    dmem_we   = 1'b0;
    dmem_addr = ir_daddr;
    case (state_q)
      ST_IDLE: begin
        halted = 1'b1;
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: state_d = ST_READ;
      ST_READ: begin
        dmem_addr = imem_data[DA_W-1:0];
        state_d   = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        dmem_we = writes_back & dest_mem;
        state_d = run ? ST_FETCH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: IR, latched ALU outputs, flags, W and PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q     <= '0;
      pc_q     <= '0;
      w_q      <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      result_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_READ: ir_q <= imem_data;
        ST_EXEC: begin
          result_q <= alu_result;
          skip_q   <= alu_pc_skip;
          c_q      <= alu_carry_out;
          z_q      <= alu_zero_out;
        end
        ST_WB: begin
          if (writes_back && !dest_mem) w_q <= result_q;
          pc_q <= pc_q + (skip_q ? PC_W'(2) : PC_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign dmem_wdata   = result_q;
  assign alu_mem      = dmem_rdata;
  assign alu_wreg     = w_q;
  assign alu_carry_in = c_q;
  assign alu_zero_in  = z_q;
  assign wreg         = w_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: exec_ctrl with a behavioural ALU and RAMs; expected
// retirements and memory writes are queued by the stimulus and checked by
// an independent monitor.
module tb_exec_ctrl;

  logic        clk, rst_n, run;
`ifdef EXEC_CTRL_STEP_EN
  logic        step;
`endif
  logic        halted;
  logic [10:0] imem_addr, dmem_addr;
  logic [15:0] imem_data, dmem_rdata, dmem_wdata;
  logic        dmem_we;
  logic [3:0]  alu_op;
  logic [15:0] alu_mem, alu_wreg, alu_result, wreg;
  logic        alu_carry_in, alu_zero_in, alu_carry_out, alu_zero_out, alu_pc_skip;

  logic [15:0] imem [0:2047];
  logic [15:0] dmem [0:2047];

  typedef struct { logic [10:0] pc; logic [15:0] w; logic c; logic z; } retire_t;
  typedef struct { logic [10:0] addr; logic [15:0] data; } wr_t;
  retire_t exp_ret[$];
  wr_t     exp_wr[$];

  int total = 0;
  int bad   = 0;

  exec_ctrl #(.PC_W(11), .DA_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef EXEC_CTRL_STEP_EN
    .step(step),
`endif
    .halted(halted), .imem_addr(imem_addr), .imem_data(imem_data),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .alu_op(alu_op), .alu_mem(alu_mem), .alu_wreg(alu_wreg),
    .alu_carry_in(alu_carry_in), .alu_zero_in(alu_zero_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .alu_zero_out(alu_zero_out), .alu_pc_skip(alu_pc_skip), .wreg(wreg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU
  always_comb begin
    logic [16:0] sum;
    sum           = '0;
    alu_result    = alu_wreg;
    alu_carry_out = alu_carry_in;
    alu_zero_out  = alu_zero_in;
    alu_pc_skip   = 1'b0;
    case (alu_op)
      4'h0: begin alu_result = {alu_mem[14:0], alu_carry_in}; alu_carry_out = alu_mem[15]; end
      4'h1: begin alu_result = {alu_carry_in, alu_mem[15:1]}; alu_carry_out = alu_mem[0]; end
      4'h2: begin
        sum = {1'b0, alu_mem} + {1'b0, alu_wreg};
        alu_result = sum[15:0]; alu_carry_out = sum[16]; alu_zero_out = (sum[15:0] == 16'h0);
      end
      4'h3: begin
        alu_result = alu_wreg - alu_mem; alu_carry_out = (alu_wreg >= alu_mem);
        alu_zero_out = (alu_wreg == alu_mem);
      end
      4'h4: begin alu_result = alu_wreg & alu_mem; alu_zero_out = ((alu_wreg & alu_mem) == 16'h0); end
      4'h5: begin alu_result = alu_wreg | alu_mem; alu_zero_out = ((alu_wreg | alu_mem) == 16'h0); end
      4'h6: begin alu_result = alu_wreg ^ alu_mem; alu_zero_out = ((alu_wreg ^ alu_mem) == 16'h0); end
      4'h7: begin alu_result = alu_mem; alu_zero_out = (alu_mem == 16'h0); end
      4'h8: alu_pc_skip = alu_zero_in;
      4'h9: alu_pc_skip = ~alu_zero_in;
      default: ;
    endcase
  end

  // Synchronous-read RAMs
  initial begin
    forever begin
      @(posedge clk);
      imem_data  <= imem[imem_addr];
      dmem_rdata <= dmem[dmem_addr];
      if (dmem_we) dmem[dmem_addr] = dmem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a PC change marks a retired instruction; dmem_we marks a write
  initial begin
    logic [10:0] prev_pc;
    retire_t r;
    wr_t     w;
    prev_pc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_pc = imem_addr;
      end else begin
        if (imem_addr != prev_pc) begin
          if (exp_ret.size() == 0) begin
            chk("unexpected_retire_pc", {21'h0, imem_addr}, 32'hFFFF_FFFF);
          end else begin
            r = exp_ret.pop_front();
            chk("retire_pc", {21'h0, imem_addr}, {21'h0, r.pc});
            chk("retire_w",  {16'h0, wreg},      {16'h0, r.w});
            chk("retire_c",  {31'h0, alu_carry_in}, {31'h0, r.c});
            chk("retire_z",  {31'h0, alu_zero_in},  {31'h0, r.z});
          end
          prev_pc = imem_addr;
        end
        if (dmem_we) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_dmem_we", {21'h0, dmem_addr}, 32'hFFFF_FFFF);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", {21'h0, dmem_addr}, {21'h0, w.addr});
            chk("wr_data", {16'h0, dmem_wdata}, {16'h0, w.data});
          end
        end
      end
    end
  end

  task automatic push_ret(input logic [10:0] pc, input logic [15:0] w, input logic c, input logic z);
    retire_t r;
    r.pc = pc; r.w = w; r.c = c; r.z = z;
    exp_ret.push_back(r);
  endtask

  task automatic init_dmem();
    for (int i = 0; i < 2048; i++) dmem[i] = 16'h0000;
    dmem[5] = 16'h0003;
    dmem[6] = 16'hFFFD;
    dmem[7] = 16'h1234;
    dmem[8] = 16'h00FF;
    dmem[9] = 16'h12CB;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_halted"}, {31'h0, halted}, 32'h1);
    chk({tag, "_we"},     {31'h0, dmem_we}, 32'h0);
    chk({tag, "_pc"},     {21'h0, imem_addr}, 32'h0);
    chk({tag, "_op"},     {28'h0, alu_op}, 32'h0);
    chk({tag, "_w"},      {16'h0, wreg}, 32'h0);
    chk({tag, "_c"},      {31'h0, alu_carry_in}, 32'h0);
    chk({tag, "_z"},      {31'h0, alu_zero_in}, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset(tag);
    rst_n = 1'b1;
  endtask

  // Expected retirements for one pass through the program (2046 instructions)
  task automatic push_pass(input logic [10:0] last_pc);
    push_ret(11'd1,  16'h0003, 1'b0, 1'b0);  // ADD->W  0+3
    exp_wr.push_back('{addr: 11'd6, data: 16'h0000});
    push_ret(11'd2,  16'h0003, 1'b1, 1'b1);  // ADD->mem 3+FFFD
    push_ret(11'd4,  16'h0003, 1'b1, 1'b1);  // PCZ, Z=1 skips
    push_ret(11'd5,  16'h0003, 1'b1, 1'b1);  // PCNZ, Z=1 no skip
    push_ret(11'd6,  16'h1234, 1'b1, 1'b0);  // ZTST 1234
    push_ret(11'd7,  16'h1234, 1'b1, 1'b0);  // PCZ, Z=0 no skip
    push_ret(11'd9,  16'h1234, 1'b1, 1'b0);  // PCNZ, Z=0 skips
    push_ret(11'd10, 16'h12CB, 1'b1, 1'b0);  // XOR 00FF
    push_ret(11'd11, 16'h0000, 1'b1, 1'b1);  // SUB 12CB
    for (int p = 12; p <= 2047; p++) push_ret(p[10:0], 16'h0000, 1'b1, 1'b1);
    push_ret(last_pc, 16'h0000, 1'b1, 1'b1);  // instruction at 0x7FF
  endtask

  task automatic run_instrs(input int n);
    @(negedge clk);
    run = 1'b1;
    repeat (4 * n) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
`ifdef EXEC_CTRL_STEP_EN
    step  = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) imem[i] = 16'hA000;
    imem[0]  = 16'h2005;
    imem[1]  = 16'h2806;
    imem[2]  = 16'h8806;
    imem[4]  = 16'h9000;
    imem[5]  = 16'h7007;
    imem[6]  = 16'h8000;
    imem[7]  = 16'h9000;
    imem[9]  = 16'h6008;
    imem[10] = 16'h3009;
    init_dmem();
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;

    // Pass 1: NOP at 0x7FF wraps to 0
    imem[2047] = 16'hA000;
    push_pass(11'h000);
    run_instrs(2046);
    chk("pass1_halted", {31'h0, halted}, 32'h1);
    chk("pass1_dmem6", {16'h0, dmem[6]}, 32'h0000);
    chk("pass1_dmem8", {16'h0, dmem[8]}, 32'h00FF);

    // Pass 2: skipping PCZ at 0x7FF wraps to 1
    do_reset("rst1");
    init_dmem();
    imem[2047] = 16'h8000;
    push_pass(11'h001);
    run_instrs(2046);
    chk("pass2_pc", {21'h0, imem_addr}, 32'h001);

    // Drop run during READ: instruction completes, then IDLE
    do_reset("rst2");
    init_dmem();
    push_ret(11'd1, 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drop_wb_not_halted", {31'h0, halted}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("drop_halted", {31'h0, halted}, 32'h1);
    repeat (4) @(negedge clk);
    chk("drop_pc_held", {21'h0, imem_addr}, 32'h001);

    // Reset during WB of a memory write: no write happens
    do_reset("rst3");
    init_dmem();
    imem[0] = 16'h2806;
    @(negedge clk);
    run = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("wb_we_before_rst", {31'h0, dmem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("wb_we_async_drop", {31'h0, dmem_we}, 32'h0);
    run = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_wb");
    chk("wb_dmem6_kept", {16'h0, dmem[6]}, 32'hFFFD);
    rst_n = 1'b1;
    imem[0] = 16'h2005;

`ifdef EXEC_CTRL_STEP_EN
    // Single step: exactly one instruction
    do_reset("rst4");
    init_dmem();
    push_ret(11'd1, 16'h0003, 1'b0, 1'b0);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
    chk("step_halted", {31'h0, halted}, 32'h1);
    chk("step_pc", {21'h0, imem_addr}, 32'h001);
`endif

    repeat (2) @(negedge clk);
    chk("ret_queue_empty", exp_ret.size(), 32'h0);
    chk("wr_queue_empty", exp_wr.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
